// File: rtl/post_add_sub_arbiter.sv
// Round-robin arbiter that shares one registered WIDTH-bit post-adder/subtracter
// between four valid/ready requesters and returns the result with carry and requester id.
module post_add_sub_arbiter #(
  parameter int WIDTH = 48
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  input  logic [3:0]         req_cin,
  input  logic [3:0]         req_sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_carry,
  output logic [1:0]         res_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [1:0]       last_grant_r;
  logic [1:0]       gid_r;
  logic [1:0]       grant_s;
  logic [1:0]       idx_s;
  logic             grant_vld_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cin_r;
  logic             sub_r;
  logic [WIDTH:0]   bcin_s;
  logic [WIDTH:0]   sum_s;

  // Round-robin pick: walk offsets 4..1 so the lowest offset after last_grant wins.
  always_comb begin
    grant_s     = 2'd0;
    grant_vld_s = 1'b0;
    idx_s       = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx_s       = last_grant_r + 2'(i);
      grant_s     = req_valid[idx_s] ? idx_s : grant_s;
      grant_vld_s = grant_vld_s | req_valid[idx_s];
    end
  end

  // b+cin is widened first so b=all-ones with cin=1 does not wrap before the subtract.
  always_comb begin
    bcin_s = {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
    sum_s  = sub_r ? ({1'b0, a_r} - bcin_s) : ({1'b0, a_r} + bcin_s);
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    next_s = grant_vld_s ? EXEC : IDLE;
      EXEC:    next_s = DONE;
      DONE:    next_s = res_ready ? IDLE : DONE;
      default: next_s = IDLE;
    endcase
  end

  // FSM outputs: one-hot ready only while idle and out of reset.
  always_comb begin
    req_ready = 4'b0000;
    if ((state_r == IDLE) && grant_vld_s && !RST) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = 4'b0000;
    end
    busy = (state_r != IDLE);
  end

  // Operand capture, arbitration history and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      cin_r        <= 1'b0;
      sub_r        <= 1'b0;
      gid_r        <= 2'd0;
      last_grant_r <= 2'd3;
      res_valid    <= 1'b0;
      res_data     <= {WIDTH{1'b0}};
      res_carry    <= 1'b0;
      res_id       <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            a_r          <= req_a[grant_s*WIDTH +: WIDTH];
            b_r          <= req_b[grant_s*WIDTH +: WIDTH];
            cin_r        <= req_cin[grant_s];
            sub_r        <= req_sub[grant_s];
            gid_r        <= grant_s;
            last_grant_r <= grant_s;
          end
        end
        EXEC: begin
          res_data  <= sum_s[WIDTH-1:0];
          res_carry <= sum_s[WIDTH];
          res_id    <= gid_r;
          res_valid <= 1'b1;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_post_add_sub_arbiter.sv
// Directed bench for post_add_sub_arbiter: a cycle model of the arbiter predicts
// ready/valid/busy each cycle and a scoreboard queue holds expected results.
module tb_post_add_sub_arbiter;

  localparam int W = 48;

  logic           CLK = 1'b0;
  logic           RST;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_cin;
  logic [3:0]     req_sub;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic           res_carry;
  logic [1:0]     res_id;
  logic           busy;

  post_add_sub_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_id(res_id), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic [1:0]   id;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] ids_seen[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         m_state;
  logic [1:0] m_last;
  bit         hold_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rr(input logic [1:0] last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(last) + k) % 4;
      if (v[idx]) return 2'(idx);
    end
    return 2'd0;
  endfunction

  function automatic exp_t model(input int g);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   r;
    exp_t         e;
    a = req_a[g*W +: W];
    b = req_b[g*W +: W];
    if (req_sub[g]) r = {1'b0, a} - ({1'b0, b} + {{W{1'b0}}, req_cin[g]});
    else            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, req_cin[g]};
    e.d  = r[W-1:0];
    e.c  = r[W];
    e.id = 2'(g);
    return e;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_sub[i]      = sub;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = 2'd3;
    sb.delete();
  endtask

  // One clock cycle: check outputs against the model, advance the model, then clock.
  task automatic step();
    logic [3:0] er;
    int         g;
    exp_t       e;
    #1;
    er = 4'b0000;
    g  = -1;
    if (m_state == 0 && req_valid != 4'b0000) begin
      g     = int'(rr(m_last, req_valid));
      er[g] = 1'b1;
    end
    chk("req_ready", {60'd0, req_ready}, {60'd0, er});
    chk("res_valid", {63'd0, res_valid}, {63'd0, m_state == 2});
    chk("busy", {63'd0, busy}, {63'd0, m_state != 0});
    if (m_state == 2) begin
      e = sb[0];
      chk("res_data", {16'd0, res_data}, {16'd0, e.d});
      chk("res_carry", {63'd0, res_carry}, {63'd0, e.c});
      chk("res_id", {62'd0, res_id}, {62'd0, e.id});
    end
    case (m_state)
      0: if (g >= 0) begin
        sb.push_back(model(g));
        m_last  = 2'(g);
        m_state = 1;
      end
      1: m_state = 2;
      2: if (res_ready) begin
        ids_seen.push_back(res_id);
        void'(sb.pop_front());
        m_state = 0;
      end
      default: m_state = 0;
    endcase
    @(posedge CLK);
    #1;
    if (g >= 0 && !hold_valid) req_valid[g] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    RST        = 1'b1;
    req_valid  = 4'b0000;
    req_a      = '0;
    req_b      = '0;
    req_cin    = 4'b0000;
    req_sub    = 4'b0000;
    res_ready  = 1'b1;
    hold_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_data", {16'd0, res_data}, 64'd0);
    chk("rst_res_carry", {63'd0, res_carry}, 64'd0);
    chk("rst_res_id", {62'd0, res_id}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    // Basic subtract on requester 0: 10 - (3 + 1) = 6.
    set_req(0, 48'd10, 48'd3, 1'b1, 1'b1);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready_same_cycle", {60'd0, req_ready}, 64'd1);
    steps(4);
    chk("t1_data", {16'd0, res_data}, 64'd6);
    chk("t1_carry", {63'd0, res_carry}, 64'd0);
    chk("t1_id", {62'd0, res_id}, 64'd0);

    // Subtract underflow on requester 2.
    set_req(2, 48'd0, 48'd1, 1'b0, 1'b1);
    req_valid = 4'b0100;
    steps(4);
    chk("t2_data", {16'd0, res_data}, {16'd0, 48'hFFFF_FFFF_FFFF});
    chk("t2_carry", {63'd0, res_carry}, 64'd1);
    chk("t2_id", {62'd0, res_id}, 64'd2);

    // Add overflow on requester 1.
    set_req(1, 48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0);
    req_valid = 4'b0010;
    steps(4);
    chk("t3_data", {16'd0, res_data}, 64'd0);
    chk("t3_carry", {63'd0, res_carry}, 64'd1);

    // b all-ones with cin=1 must not wrap before the subtract.
    set_req(3, 48'd5, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1);
    req_valid = 4'b1000;
    steps(4);
    chk("t4_data", {16'd0, res_data}, 64'd5);
    chk("t4_carry", {63'd0, res_carry}, 64'd1);
    chk("t4_id", {62'd0, res_id}, 64'd3);

    // Fairness: all four held valid for eight operations.
    for (int i = 0; i < 4; i++) set_req(i, W'(100 * i + 7), W'(i + 1), i[0], i[1]);
    ids_seen.delete();
    hold_valid = 1'b1;
    req_valid  = 4'b1111;
    steps(24);
    req_valid  = 4'b0000;
    hold_valid = 1'b0;
    chk("rr_count", 64'(ids_seen.size()), 64'd8);
    for (int k = 0; k < 8 && k < ids_seen.size(); k++) begin
      chk($sformatf("rr_seq%0d", k), {62'd0, ids_seen[k]}, 64'(k % 4));
    end

    // Backpressure: five stalled cycles in DONE with other requesters waiting.
    res_ready = 1'b0;
    set_req(1, 48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b1, 1'b0);
    req_valid = 4'b0010;
    steps(2);
    req_valid = 4'b0101;
    steps(5);
    chk("bp_data", {16'd0, res_data}, {16'd0, 48'h2345_6789_ABCE});
    chk("bp_id", {62'd0, res_id}, 64'd1);
    res_ready = 1'b1;
    step();
    // Requester 2 follows requester 1 in rotation; reset it mid-EXEC.
    step();
    req_valid = 4'b0000;
    RST = 1'b1;
    #1;
    chk("rst_exec_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_exec_busy", {63'd0, busy}, 64'd0);
    chk("rst_exec_req_ready", {60'd0, req_ready}, 64'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    steps(3);
    req_valid = 4'b1001;
    #1;
    chk("post_rst_grant0", {60'd0, req_ready}, 64'd1);
    steps(8);
    chk("post_rst_last_id", {62'd0, res_id}, 64'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/post_add_sub_arbiter.md
Name: post_add_sub_arbiter

Overview:
- Round-robin scheduler that shares one 48-bit post-adder/subtracter between four requesters.
- Each requester presents operands and an op select through a valid/ready handshake.
- The block captures the granted operands, computes the result in a registered stage, and returns it with the carry bit and the requester ID through a valid/ready result port.
- It sits between the DSP48A1 multiplier/pre-adder clients and the post-adder datapath.

Parameters:
- WIDTH, 48, operand and result width.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- req_valid  input  4  per-requester request valid.
- req_ready  output  4  per-requester accept; one-hot or zero.
- req_a  input  4*WIDTH  in0 operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  4*WIDTH  in1 operands, packed the same way as req_a.
- req_cin  input  4  per-requester carry-in (in2).
- req_sub  input  4  per-requester op select: 1 = subtract, 0 = add.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accept.
- res_data  output  WIDTH  result.
- res_carry  output  1  bit WIDTH of the (WIDTH+1)-bit result.
- res_id  output  2  index of the requester that produced the result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Arithmetic, computed at WIDTH+1 bits with zero-extended operands:
  - sub=1: {res_carry,res_data} = a - (b + cin). b+cin is formed at WIDTH+1 bits, so b = all-ones with cin=1 does not wrap before the subtract.
  - sub=0: {res_carry,res_data} = a + b + cin, modulo 2^(WIDTH+1).
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req_valid is high, pick grant g = first set bit searching upward, with wrap, from last_grant+1.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge: capture a/b/cin/sub of g into operand registers, set gid<=g and last_grant<=g, go to EXEC.
  - If no req_valid is high, stay in IDLE with req_ready=0.
- EXEC:
  - req_ready=0.
  - On the edge: register the adder output into res_data/res_carry, set res_id<=gid and res_valid<=1, go to DONE.
- DONE:
  - req_ready=0. res_valid, res_data, res_carry and res_id are held stable.
  - When res_ready=1: on the edge res_valid<=0 and the FSM goes to IDLE.
  - Data fields keep their last value after res_valid drops.
- Latency and throughput:
  - Handshake cycle N gives res_valid high from cycle N+2.
  - Minimum initiation interval is 3 cycles; there is no grant in the cycle res_ready is accepted.
- req_ready is never asserted outside IDLE. Requesters must hold req_valid and operands until they see ready; any deassert before that is ignored.
- Fairness: a requester that holds valid is granted within 4 grants.
- Simultaneous events: all four requesters valid in IDLE gives exactly one grant. The rest wait, and their ready stays 0.
- Reset values:
  - FSM = IDLE, last_grant = 3, so requester 0 has first priority.
  - Operand registers = 0.
  - res_valid = 0, res_data = 0, res_carry = 0, res_id = 0, busy = 0, req_ready = 0.
- Reset mid-operation (EXEC or DONE) abandons the operation. The result is lost and no res_valid pulse appears after reset release.
- res_ready high while res_valid is 0 has no effect.

Test Plan:
- Reset, then req_valid=0001, a=10, b=3, cin=1, sub=1:
  - req_ready=0001 in the same cycle.
  - 2 cycles later res_valid=1, res_data=6, res_carry=0, res_id=0.
- Subtract underflow on requester 2, a=0, b=1, cin=0, sub=1 -> res_data=48'hFFFF_FFFF_FFFF, res_carry=1, res_id=2.
- Add overflow, a=48'hFFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> res_data=0, res_carry=1.
- Subtract with b all-ones and cin=1, a=5 -> (5 - 2^48) mod 2^49, so res_data=5, res_carry=1.
- Hold all req_valid=1111 with res_ready=1 and run 8 operations -> res_id sequence 0,1,2,3,0,1,2,3 with one grant per 3 cycles.
- Backpressure and reset:
  - Hold res_ready=0 for 5 cycles in DONE -> outputs stable and req_ready=0 throughout.
  - Assert RST in EXEC -> res_valid=0 immediately and stays 0 after release; next grant goes to requester 0.
